rf_scoreboard: RTL
==================

# rf_scoreboard

Register-file scoreboard and issue controller for the RV32E decode stage. It tracks the in-flight writes to each of the 16 architectural registers and stalls the decode stage on RAW hazards or write-count overflow. It credits same-cycle writebacks that the decode stage already bypasses, so those do not cause a stall. It sits beside the decode stage: it takes the decoded register addresses from that stage and the writeback bus from the WB stage, and returns a ready/stall signal to the fetch/decode pipeline registers.

## Interface
- NREG, 16, number of tracked registers (RV32E); x0 is never tracked
- CNT_W, 2, width of the per-register in-flight write counter; maximum is 2^CNT_W-1

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  decode stage holds a valid instruction
- id_rs1_addr, id_rs2_addr  in  4  source register addresses
- id_rs1_used, id_rs2_used  in  1  instruction actually reads rs1/rs2
- id_rd_addr  in  4  destination address
- id_reg_write  in  1  instruction writes rd
- wb_valid  in  1  writeback this cycle (same signal as the register-file write enable)
- wb_rd_addr  in  4  writeback destination
- flush  in  1  kill all in-flight instructions (trap/redirect)
- id_ready  out  1  instruction may issue this cycle; issue = id_valid & id_ready
- stall  out  1  id_valid & ~id_ready
- hazard_rs1, hazard_rs2  out  1  RAW hazard detected per source operand
- busy_mask  out  16  bit r set when cnt[r] != 0
- inflight  out  6  total outstanding tracked writes
- stall_cnt  out  16  saturating count of stall cycles
- err_underflow  out  1  sticky: writeback to a register with cnt == 0

## Operation
- State: cnt[1..15] (CNT_W bits each), inflight, stall_cnt, err_underflow. cnt[0] is constant 0.
- avail(r) is true when cnt[r] == 0, or when cnt[r] == 1 and wb_valid and wb_rd_addr == r. The second case covers the write the decode stage bypasses this cycle.
- hazard_rsN = id_rsN_used & (id_rsN_addr != 0) & ~avail(id_rsN_addr).
- waw_full = id_reg_write & (id_rd_addr != 0) & (cnt[id_rd_addr] == max), with no decrement of that register this cycle.
- id_ready = ~flush & ~hazard_rs1 & ~hazard_rs2 & ~waw_full. It is combinational and independent of id_valid.
- Counter update on each clock edge (not flush):
  - inc = issue & id_reg_write & rd != 0
  - dec = wb_valid & wb_rd != 0 & cnt[wb_rd] != 0
  - Same register inc and dec: cnt unchanged.
  - Different registers: each updates independently.
  - inflight changes by inc - dec.
- Writeback with wb_rd != 0 and cnt == 0: no decrement; err_underflow is set and held until rst.
- wb_rd_addr == 0: ignored entirely.
- flush: every cnt and inflight go to 0 at the next edge. Writeback and issue in that cycle are ignored. stall_cnt and err_underflow are retained. Upstream guarantees killed instructions never write back.
- stall_cnt increments each cycle that stall = 1 and saturates at 16'hFFFF.
- Source equal to destination (e.g. add x3,x3,x1): hazard is checked against the pre-issue cnt. The instruction's own write never blocks itself.

## Timing
- Reset (synchronous): all cnt = 0, inflight = 0, stall_cnt = 0, err_underflow = 0. Therefore busy_mask = 0 and id_ready = 1 (unless flush is high).
- id_ready, stall and hazard_* are combinational, same cycle as the inputs. busy_mask and inflight are registered-state derived, valid one cycle after the update.
- An issued write makes its rd busy from the next cycle. The earliest dependent instruction may issue in the cycle its producer's wb_valid is high (zero-bubble bypass credit).
- rst asserted during in-flight operation: all state clears regardless of flush or wb_valid. rst has priority over flush.

## Test plan
- Reset, then id_valid=1, rs1=5 used, no writebacks -> id_ready=1, busy_mask=0, stall_cnt=0.
- Issue rd=3 write. Next cycle rs1=3 -> hazard_rs1=1, stall=1 until wb_valid with wb_rd=3. In that cycle id_ready=1. busy_mask[3] returns to 0 the cycle after.
- Issue three writes to rd=7 (cnt=3). A fourth write to rd=7 -> waw_full, stall. With a same-cycle wb to 7 -> issues, cnt stays 3.
- Same-cycle issue to rd=2 and wb to rd=2 with cnt[2]=1 -> cnt[2]=1, inflight unchanged.
- wb_valid, wb_rd=9 with cnt[9]=0 -> err_underflow=1 and stays 1 after later traffic. wb_rd=0 -> no effect.
- Fill cnt on x1/x4, hold stall 5 cycles, then flush=1 -> id_ready=0 that cycle. Next cycle busy_mask=0, inflight=0, stall_cnt=5 retained.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register in-flight write tracking and issue control for
// the RV32E decode stage. Stalls decode on RAW hazards or write-counter
// overflow, and credits same-cycle writebacks that decode already bypasses.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_valid                  decode holds a valid instruction
//   id_rs1_addr/id_rs2_addr   source register addresses
//   id_rs1_used/id_rs2_used   instruction reads rs1/rs2
//   id_rd_addr, id_reg_write  destination and write enable of decode instr
//   wb_valid, wb_rd_addr      writeback bus from WB stage
//   flush                     kill all in-flight instructions
//   id_ready                  instruction may issue (comb, ignores id_valid)
//   stall                     id_valid & ~id_ready (comb)
//   hazard_rs1/hazard_rs2     RAW hazard per source operand (comb)
//   busy_mask                 bit r set while cnt[r] != 0
//   inflight                  total outstanding tracked writes
//   stall_cnt                 saturating stall-cycle counter
//   err_underflow             sticky writeback-to-idle-register error
module rf_scoreboard #(
  parameter int unsigned NREG  = 16,
  parameter int unsigned CNT_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [$clog2(NREG)-1:0] id_rs1_addr,
  input  logic [$clog2(NREG)-1:0] id_rs2_addr,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [$clog2(NREG)-1:0] id_rd_addr,
  input  logic                    id_reg_write,
  input  logic                    wb_valid,
  input  logic [$clog2(NREG)-1:0] wb_rd_addr,
  input  logic                    flush,
  output logic                    id_ready,
  output logic                    stall,
  output logic                    hazard_rs1,
  output logic                    hazard_rs2,
  output logic [NREG-1:0]         busy_mask,
  output logic [5:0]              inflight,
  output logic [15:0]             stall_cnt,
  output logic                    err_underflow
);

  localparam int unsigned AW    = $clog2(NREG);
  localparam int unsigned INF_W = 6;
  localparam int unsigned SC_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
  logic             rs1_avail, rs2_avail, waw_full;
  logic             inc, dec, underflow_hit;

  // Hazard detection and issue decision; a count of one that is being
  // written back this cycle is available through the decode bypass.
  always_comb begin
    rs1_cnt    = cnt_q[id_rs1_addr];
    rs2_cnt    = cnt_q[id_rs2_addr];
    rd_cnt     = cnt_q[id_rd_addr];
    wb_cnt     = cnt_q[wb_rd_addr];
    rs1_avail  = (rs1_cnt == '0) ||
                 ((rs1_cnt == CNT_W'(1)) && wb_valid && (wb_rd_addr == id_rs1_addr));
    rs2_avail  = (rs2_cnt == '0) ||
                 ((rs2_cnt == CNT_W'(1)) && wb_valid && (wb_rd_addr == id_rs2_addr));
    hazard_rs1 = id_rs1_used && (id_rs1_addr != '0) && !rs1_avail;
    hazard_rs2 = id_rs2_used && (id_rs2_addr != '0) && !rs2_avail;
    // A full counter can still accept a new write if it drains this cycle.
    waw_full   = id_reg_write && (id_rd_addr != '0) && (rd_cnt == CNT_MAX) &&
                 !(wb_valid && (wb_rd_addr == id_rd_addr));
    id_ready   = !flush && !hazard_rs1 && !hazard_rs2 && !waw_full;
    stall      = id_valid && !id_ready;

    inc           = id_valid && id_ready && id_reg_write && (id_rd_addr != '0);
    dec           = !flush && wb_valid && (wb_rd_addr != '0) && (wb_cnt != '0);
    underflow_hit = !flush && wb_valid && (wb_rd_addr != '0) && (wb_cnt == '0);
  end

  // Next-state for counters, inflight total, stall counter and error flag.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush || (r == 0)) begin
        cnt_d[r] = '0;
      end else begin
        if (inc && (id_rd_addr == AW'(r)) && !(dec && (wb_rd_addr == AW'(r)))) begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end else if (dec && (wb_rd_addr == AW'(r)) && !(inc && (id_rd_addr == AW'(r)))) begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
    end

    inflight_d = flush ? '0 : (inflight_q + INF_W'(inc) - INF_W'(dec));

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + SC_W'(1);
    end

    err_d = err_q || underflow_hit;
  end

  // State registers; reset overrides flush and all other activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) busy_mask[r] = (cnt_q[r] != '0);
  end

  assign inflight      = inflight_q;
  assign stall_cnt     = stall_cnt_q;
  assign err_underflow = err_q;

endmodule
